// File: rtl/lzd_denormalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzd_denormalizer_pkg
// Brief    : Shared constants, stage payload type and mask helper for the
//            three-stage denormalizing barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
package lzd_denormalizer_pkg;

    localparam int C_DEF_WIDTH = 32;
    localparam int C_DEF_CNT_W = $clog2(C_DEF_WIDTH);

    // Payload is sized for the widest legal datapath; narrower configs zero-extend.
    localparam int C_PAY_W  = 32;
    localparam int C_REM_W  = 3;
    localparam int C_SH_W   = 6;

    localparam int C_S1_LO  = 3;
    localparam int C_S2_HI  = 2;
    localparam int C_S2_LO  = 1;
    localparam int C_S3_BIT = 0;

    localparam int C_S1_GRAN = 8;
    localparam int C_S2_GRAN = 2;
    localparam int C_S3_GRAN = 1;

    typedef struct packed {
        logic [C_PAY_W-1:0] data;
        logic [C_REM_W-1:0] cnt_rem;
        logic               zero;
        logic               sticky;
        logic               valid;
    } stage_pay_t;

    function automatic logic [C_PAY_W-1:0] low_mask(input logic [C_SH_W-1:0] sh);
        return ~({C_PAY_W{1'b1}} << sh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzd_denormalizer_if.sv
`default_nettype none
// ============================================================================
// Module   : lzd_denormalizer_if
// Brief    : Input and output valid/ready channels of the denormalizer.
// Revision : 1.0 - initial release
// ============================================================================
interface lzd_denormalizer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [CNT_W-1:0] in_cnt;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_inexact;

    modport master (
        output in_valid, in_mant, in_cnt, in_zero, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    modport slave (
        input  in_valid, in_mant, in_cnt, in_zero, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface
`default_nettype wire

// File: rtl/lzd_denormalizer_shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : denorm_shift_stage
// Brief    : One registered barrel-shifter stage: shifts by shamt*GRANULE and
//            accumulates the discarded bits into the sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module denorm_shift_stage
    import lzd_denormalizer_pkg::*;
#(
    parameter int GRANULE = 1,
    parameter int SLICE_W = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_en,
    input  wire stage_pay_t         i_pay,
    input  wire logic [SLICE_W-1:0] i_shamt,
    output stage_pay_t              o_pay
);

    logic [C_SH_W-1:0] w_sh;
    stage_pay_t        w_next;
    stage_pay_t        r_pay;

    assign w_sh = C_SH_W'(i_shamt) * C_SH_W'(GRANULE);

    always_comb begin
        w_next        = i_pay;
        w_next.data   = i_pay.data >> w_sh;
        w_next.sticky = i_pay.sticky | (|(i_pay.data & low_mask(w_sh)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pay <= '0;
        end else if (i_en) begin
            r_pay <= w_next;
        end
    end

    assign o_pay = r_pay;

endmodule
`default_nettype wire

// File: rtl/lzd_denormalizer.sv
`default_nettype none
// ============================================================================
// Module   : lzd_denormalizer
// Brief    : Restores a fixed-point value from a normalized mantissa and its
//            leading-zero count via a 3-stage pipelined logical right shift.
// Revision : 1.0 - initial release
// ============================================================================
module lzd_denormalizer
    import lzd_denormalizer_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lzd_denormalizer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int S1_W  = CNT_W - C_S1_LO;

    if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
        $error("lzd_denormalizer: WIDTH must be 16 or 32");
    end

    logic       w_en;
    stage_pay_t w_s1_in;
    stage_pay_t w_s1;
    stage_pay_t w_s2;
    stage_pay_t w_s3;
    logic       w_unused;

    // A single enable freezes the whole pipe, so bubbles never block advance.
    assign w_en = !w_s3.valid || bus.out_ready;

    always_comb begin
        w_s1_in         = '0;
        w_s1_in.valid   = bus.in_valid;
        w_s1_in.zero    = bus.in_zero;
        w_s1_in.cnt_rem = bus.in_cnt[C_REM_W-1:0];
        w_s1_in.sticky  = 1'b0;
        w_s1_in.data    = bus.in_zero ? '0 : C_PAY_W'(bus.in_mant);
    end

    denorm_shift_stage #(
        .GRANULE (C_S1_GRAN),
        .SLICE_W (S1_W)
    ) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_pay   (w_s1_in),
        .i_shamt (bus.in_cnt[CNT_W-1:C_S1_LO]),
        .o_pay   (w_s1)
    );

    denorm_shift_stage #(
        .GRANULE (C_S2_GRAN),
        .SLICE_W (C_S2_HI - C_S2_LO + 1)
    ) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_pay   (w_s1),
        .i_shamt (w_s1.cnt_rem[C_S2_HI:C_S2_LO]),
        .o_pay   (w_s2)
    );

    denorm_shift_stage #(
        .GRANULE (C_S3_GRAN),
        .SLICE_W (1)
    ) u_stage3 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_pay   (w_s2),
        .i_shamt (w_s2.cnt_rem[C_S3_BIT]),
        .o_pay   (w_s3)
    );

    assign bus.in_ready    = w_en;
    assign bus.out_valid   = w_s3.valid;
    assign bus.out_data    = w_s3.data[WIDTH-1:0];
    assign bus.out_inexact = w_s3.sticky & ~w_s3.zero;

    // Remaining count bits and the zero-extended upper payload end here.
    assign w_unused = ^{w_s3.data, w_s3.cnt_rem};

endmodule
`default_nettype wire

// File: tb/tb_lzd_denormalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzd_denormalizer
// Brief    : Scoreboard bench for lzd_denormalizer with a shift/remainder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzd_denormalizer;

    typedef struct {
        logic [31:0] d;
        logic        x;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   n_out;
    exp_t sb[$];
    bit   prev_stall;
    logic [31:0] prev_d;
    logic        prev_x;
    bit   rnd_done;

    lzd_denormalizer_if #(.WIDTH(32)) bus ();

    lzd_denormalizer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] m, input int c, input logic z);
        exp_t e;
        longint unsigned full;
        full = 64'(m);
        if (z) begin
            e.d = 32'd0;
            e.x = 1'b0;
        end else begin
            e.d = 32'(full >> c);
            e.x = (full % (64'd1 << c)) != 64'd0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_mant, int'(bus.in_cnt), bus.in_zero));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", bus.out_data, e.d);
                    check("sb_inexact", 32'(bus.out_inexact), 32'(e.x));
                end
                n_out++;
            end else if (bus.out_valid) begin
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                if (prev_stall) begin
                    check("stall_hold_data", bus.out_data, prev_d);
                    check("stall_hold_inexact", 32'(bus.out_inexact), 32'(prev_x));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_x     = bus.out_inexact;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] m, input logic [4:0] c, input logic z);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_cnt   = c;
        bus.in_zero  = z;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic directed(input logic [31:0] m, input logic [4:0] c, input logic z,
                            input logic [31:0] ed, input logic ex, input string nm);
        int  n;
        bit  seen;
        bus.out_ready = 1'b1;
        send(m, c, z);
        n    = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        check({nm, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'd3);
        check({nm, "_data"}, bus.out_data, ed);
        check({nm, "_inexact"}, 32'(bus.out_inexact), 32'(ex));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int out_before;
        checks = 0; fails = 0; n_out = 0;
        prev_stall = 1'b0; prev_d = '0; prev_x = 1'b0; rnd_done = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_cnt = '0; bus.in_zero = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        directed(32'h8000_0000, 5'd0,  1'b0, 32'h8000_0000, 1'b0, "cnt0");
        directed(32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001, 1'b1, "cnt31");
        directed(32'hC000_0000, 5'd4,  1'b0, 32'h0C00_0000, 1'b0, "cnt4");
        directed(32'hF000_000F, 5'd8,  1'b0, 32'h00F0_0000, 1'b1, "cnt8");
        directed(32'hFFFF_FFFF, 5'd7,  1'b1, 32'h0000_0000, 1'b0, "zero");
        drain("directed_drain");

        // Eight back-to-back beats with a five-cycle output stall mid-stream.
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h8000_0000 | ($urandom & 32'h7FFF_FFFF), 5'($urandom_range(0, 31)), 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_count", 32'(n_out - out_before), 32'd8);

        // Randomized traffic with random backpressure.
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send(32'h8000_0000 | ($urandom & 32'h7FFF_FFFF), 5'($urandom_range(0, 31)),
                         $urandom_range(0, 9) == 0);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = $urandom_range(0, 9) < 7;
                end
            end
        join
        drain("random_drain");
        check("random_count", 32'(n_out - out_before), 32'd300);

        // Fill the pipe under backpressure, then reset between clock edges.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hFFFF_FFFF, 5'd4, 1'b0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", bus.out_data, 32'd0);
        check("midrst_out_inexact", 32'(bus.out_inexact), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_before = n_out;
        directed(32'h8000_0000, 5'd16, 1'b0, 32'h0000_8000, 1'b0, "post_rst");
        drain("post_rst_drain");
        check("post_rst_count", 32'(n_out - out_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
